// File: rtl/mic1_exec_ctrl.sv
// mic1_exec_ctrl: execution controller for the MIC-1 core.
// Drives the core's active-low reset and run enable. After any reset the core
// is held in reset for RESET_HOLD_CYCLES cycles, then enters RUN or HALT
// (START_RUN). From there single-cycle request pulses select free-run, halt or
// a single step of STEP_CYCLES run cycles.
//
// Optional feature: define MIC1_EXEC_CTRL_BREAK_EN to build the micro-PC
// breakpoint comparator. Without it mpc/break_addr/break_valid are ignored and
// break_hit is tied low.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   run_req, halt_req      one-cycle request pulses
//   step_req               one-cycle request pulse for a single step
//   soft_reset_req         one-cycle request pulse for a core reset
//   mpc, break_addr        current micro-PC and breakpoint address
//   break_valid            breakpoint armed
//   core_resetn, run       registered controls to mic1_soc
//   state                  0 HOLD, 1 RUN, 2 HALT, 3 STEP
//   step_done, break_hit   one-cycle status pulses
module mic1_exec_ctrl #(
   parameter int unsigned RESET_HOLD_CYCLES = 16,
   parameter int unsigned STEP_CYCLES       = 1,
   parameter bit          START_RUN         = 1'b1,
   parameter int unsigned ADDR_W            = 9
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              run_req,
   input  logic              halt_req,
   input  logic              step_req,
   input  logic              soft_reset_req,
   input  logic [ADDR_W-1:0] mpc,
   input  logic [ADDR_W-1:0] break_addr,
   input  logic              break_valid,
   output logic              core_resetn,
   output logic              run,
   output logic [1:0]        state,
   output logic              step_done,
   output logic              break_hit
);

   localparam logic [1:0] ST_HOLD = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;
   localparam logic [1:0] ST_STEP = 2'd3;

   localparam logic [15:0] HOLD_LOAD  = 16'(RESET_HOLD_CYCLES - 1);
   localparam logic [7:0]  STEP_LOAD  = 8'(STEP_CYCLES - 1);
   localparam logic [1:0]  AFTER_HOLD = START_RUN ? ST_RUN : ST_HALT;

   logic [1:0]  state_q, state_d;
   logic [15:0] hold_cnt_q, hold_cnt_d;
   logic [7:0]  step_cnt_q, step_cnt_d;
   logic        run_q, core_resetn_q, step_done_q, break_hit_q;
   logic        break_hit_d;
   logic        brk;

`ifdef MIC1_EXEC_CTRL_BREAK_EN
   // Only a core that is actually executing can hit a breakpoint.
   assign brk = break_valid && (mpc == break_addr) &&
                ((state_q == ST_RUN) || (state_q == ST_STEP));
`else
   logic unused_break;
   assign unused_break = ^{mpc, break_addr, break_valid};
   assign brk          = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      step_cnt_d  = step_cnt_q;
      break_hit_d = 1'b0;
      if (state_q == ST_HOLD) begin
         if (soft_reset_req) begin
            hold_cnt_d = HOLD_LOAD;
         end else if (hold_cnt_q == 16'd0) begin
            state_d = AFTER_HOLD;
         end else begin
            hold_cnt_d = hold_cnt_q - 16'd1;
         end
      end else if (soft_reset_req) begin
         state_d    = ST_HOLD;
         hold_cnt_d = HOLD_LOAD;
      end else if (brk) begin
         state_d     = ST_HALT;
         break_hit_d = 1'b1;
      end else if (halt_req) begin
         // Also swallows lower-priority step/run requests while halted.
         state_d = ST_HALT;
      end else if (step_req && (state_q == ST_HALT)) begin
         state_d    = ST_STEP;
         step_cnt_d = STEP_LOAD;
      end else if (run_req && (state_q == ST_HALT)) begin
         state_d = ST_RUN;
      end else if (state_q == ST_STEP) begin
         if (step_cnt_q == 8'd0) begin
            state_d = ST_HALT;
         end else begin
            step_cnt_d = step_cnt_q - 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_HOLD;
         hold_cnt_q    <= HOLD_LOAD;
         step_cnt_q    <= 8'd0;
         run_q         <= 1'b0;
         core_resetn_q <= 1'b0;
         step_done_q   <= 1'b0;
         break_hit_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         step_cnt_q    <= step_cnt_d;
         run_q         <= (state_d == ST_RUN) || (state_d == ST_STEP);
         core_resetn_q <= (state_d != ST_HOLD);
         // Registered one cycle early so the pulse lands in the last run cycle of the step.
         step_done_q   <= (state_d == ST_STEP) && (step_cnt_d == 8'd0);
         break_hit_q   <= break_hit_d;
      end
   end

   assign state       = state_q;
   assign run         = run_q;
   assign core_resetn = core_resetn_q;
   assign step_done   = step_done_q;
   assign break_hit   = break_hit_q;

endmodule

// File: doc/mic1_exec_ctrl.md
# mic1_exec_ctrl

Execution controller for the MIC-1 SoC on the iCEBreaker top level. It owns the core's `resetn` and `run` inputs. It sequences a power-on/soft reset hold, then free-run, halt and single-step modes, driven by single-cycle request pulses from the debounced board buttons or a debug source. An optional breakpoint comparator halts the core when the micro-PC hits a programmed address.

## Interface
Parameters:
- `RESET_HOLD_CYCLES`, 16: cycles `core_resetn` is held low after any reset; legal range 1..65535.
- `STEP_CYCLES`, 1: cycles `run` is asserted per step request; legal range 1..255.
- `START_RUN`, 1: state after reset hold; 1 = RUN, 0 = HALT.
- `ADDR_W`, 9: micro-PC width for the breakpoint compare.

Ports:
- `clk` in 1: system clock.
- `resetn` in 1: asynchronous active-low reset.
- `run_req` in 1: one-cycle pulse requesting free-run.
- `halt_req` in 1: one-cycle pulse requesting halt.
- `step_req` in 1: one-cycle pulse requesting a single step.
- `soft_reset_req` in 1: one-cycle pulse requesting a core reset.
- `mpc` in ADDR_W: current micro-PC from the core.
- `break_addr` in ADDR_W: breakpoint address.
- `break_valid` in 1: breakpoint armed.
- `core_resetn` out 1: registered reset to mic1_soc, active-low.
- `run` out 1: registered run enable to mic1_soc.
- `state` out 2: 0 = HOLD, 1 = RUN, 2 = HALT, 3 = STEP.
- `step_done` out 1: one-cycle pulse on STEP→HALT.
- `break_hit` out 1: one-cycle pulse when a breakpoint halts the core.

## Operation
- States are HOLD, RUN, HALT and STEP. `run` is 1 only in RUN and STEP. `core_resetn` is 0 only in HOLD.
- HOLD:
  - A 16-bit hold counter loads `RESET_HOLD_CYCLES-1` on entry and decrements every cycle.
  - At 0 the FSM goes to RUN if `START_RUN` = 1, else to HALT.
  - All requests are ignored in HOLD except `soft_reset_req`, which reloads the counter.
- Request priority, evaluated every cycle outside HOLD: `soft_reset_req` > breakpoint > `halt_req` > `step_req` > `run_req`. Only the highest-priority request takes effect; the others are dropped, not queued.
- `soft_reset_req` in any state → HOLD.
- RUN:
  - `halt_req` → HALT.
  - `step_req` and `run_req` have no effect.
- HALT:
  - `run_req` → RUN.
  - `step_req` → STEP, and the step counter loads `STEP_CYCLES-1`.
  - `halt_req` has no effect.
- STEP:
  - The step counter decrements every cycle.
  - At 0 → HALT, and `step_done` pulses in the same cycle as the transition.
  - `halt_req` aborts to HALT immediately, with no `step_done`.
  - `step_req` and `run_req` during STEP are ignored.
- Counters do not wrap. Each is loaded only on state entry and stops at 0.

## Timing
- Asynchronous reset values:
  - state = HOLD, `core_resetn` = 0, `run` = 0.
  - `step_done` = 0, `break_hit` = 0.
  - Hold counter = `RESET_HOLD_CYCLES-1`, step counter = 0.
- All outputs are registered. A request sampled at edge N changes `state`, `run` and `core_resetn` after edge N (visible in cycle N+1).
- `core_resetn` rises exactly `RESET_HOLD_CYCLES` cycles after `resetn` deasserts. If `START_RUN` = 1, `run` rises in the same cycle.
- A step asserts `run` for exactly `STEP_CYCLES` consecutive cycles, and `step_done` pulses in the last of those cycles.
- Asserting `resetn` mid-step or mid-hold returns to HOLD immediately and asynchronously. The counters reload and the step in progress is discarded.
- Breakpoint latency: a `mpc` match sampled at edge N drops `run` in cycle N+1. The core therefore executes the matched microinstruction.

## Configuration
- Macro: `MIC1_EXEC_CTRL_BREAK_EN`.
- When defined:
  - In RUN or STEP, `break_valid` && (`mpc` == `break_addr`) forces HALT and pulses `break_hit`.
  - A breakpoint overrides `halt_req` and the step counter.
  - A breakpoint in STEP suppresses `step_done`.
- When not defined:
  - The ports remain but `mpc`, `break_addr` and `break_valid` are ignored.
  - `break_hit` is tied to 0.
  - No comparator logic is synthesised.

## Test plan
- Power-on:
  - Setup: `RESET_HOLD_CYCLES` = 16, `START_RUN` = 1, release `resetn` at cycle 0.
  - Required: `core_resetn` = 0 for cycles 0–15; `core_resetn` = 1 and `run` = 1 from cycle 16; `state` = 1.
- Halt then step:
  - Setup: `STEP_CYCLES` = 3. `halt_req` at cycle 40, then `step_req` at cycle 50.
  - Required: `run` = 0 from cycle 41; `run` = 1 for cycles 51–53; `step_done` at cycle 53; `state` = 2 from cycle 54.
- Simultaneous requests:
  - `halt_req` and `run_req` in the same cycle while in RUN → HALT.
  - `step_req` and `run_req` together while in HALT → STEP.
- Soft reset mid-step:
  - `soft_reset_req` in the 2nd step cycle → `core_resetn` = 0 for 16 cycles, no `step_done`, then RUN.
- Breakpoint (macro defined):
  - Setup: `break_addr` = 0x1A, `break_valid` = 1; `mpc` reaches 0x1A at cycle N.
  - Required: `break_hit` at cycle N+1, `run` = 0 from N+1. With the macro undefined, `run` stays 1.
- Async reset:
  - Assert `resetn` = 0 mid-cycle during RUN → `run` = 0 and `core_resetn` = 0 immediately, before the next clock edge.
